operand_fetch_stage: RTL and testbench

//  Decode/operand-fetch stage feeding the ALU: decodes an 8-bit instruction, reads the 4x8 register file,

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/reg_file_2r1w.sv | 36 +++
 rtl/operand_fetch_stage.sv | 120 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the operand-fetch stage: datapath sizes, opcodes
// and the bit positions of the instruction fields.
package cpu_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned NUM_REGS  = 4;
   localparam int unsigned REG_IDX_W = 2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   // instr layout: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd/imm
   localparam int unsigned OP_MSB = 7;
   localparam int unsigned OP_LSB = 6;
   localparam int unsigned RS_MSB = 5;
   localparam int unsigned RS_LSB = 4;
   localparam int unsigned RT_MSB = 3;
   localparam int unsigned RT_LSB = 2;
   localparam int unsigned RD_MSB = 1;
   localparam int unsigned RD_LSB = 0;

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file with two combinational read ports and one write port.
// A read of the register being written this cycle returns the write data.
module reg_file_2r1w #(
   parameter int unsigned DATA_W    = cpu_pkg::DATA_W,
   parameter int unsigned NUM_REGS  = cpu_pkg::NUM_REGS,
   parameter int unsigned REG_IDX_W = cpu_pkg::REG_IDX_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [REG_IDX_W-1:0] raddr1,
   output logic [DATA_W-1:0]    rdata1,
   input  logic [REG_IDX_W-1:0] raddr2,
   output logic [DATA_W-1:0]    rdata2,
   input  logic                 wen,
   input  logic [REG_IDX_W-1:0] waddr,
   input  logic [DATA_W-1:0]    wdata
);

   logic [DATA_W-1:0] mem_q [NUM_REGS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wen) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = (wen && (waddr == raddr1)) ? wdata : mem_q[raddr1];
      rdata2 = (wen && (waddr == raddr2)) ? wdata : mem_q[raddr2];
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: decodes the instruction, reads operands,
// tracks in-flight destinations to stall RAW hazards, and registers one bundle.
module operand_fetch_stage #(
   parameter int unsigned DATA_W    = cpu_pkg::DATA_W,
   parameter int unsigned NUM_REGS  = cpu_pkg::NUM_REGS,
   parameter int unsigned REG_IDX_W = cpu_pkg::REG_IDX_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [7:0]           instr,
   input  logic                 wb_en,
   input  logic [REG_IDX_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]    wb_data,
   output logic                 op_valid,
   input  logic                 op_ready,
   output logic [1:0]           op_code,
   output logic [REG_IDX_W-1:0] dest,
   output logic [DATA_W-1:0]    readdata1,
   output logic [DATA_W-1:0]    readdata2,
   output logic [DATA_W-1:0]    sign_extended,
   output logic                 alusrc
);

   import cpu_pkg::*;

   logic [1:0]           op;
   logic [REG_IDX_W-1:0] rs, rt, rd;
   logic                 uses_rs, uses_rt, writes_reg, hz, load;
   logic [REG_IDX_W-1:0] dest_d;
   logic [DATA_W-1:0]    rf_rd1, rf_rd2, sext_d;
   logic [NUM_REGS-1:0]  pend_q, pend_d;

   logic                 op_valid_q;
   logic [1:0]           op_code_q;
   logic [REG_IDX_W-1:0] dest_q;
   logic [DATA_W-1:0]    readdata1_q, readdata2_q, sext_q;
   logic                 alusrc_q;

   assign op = instr[OP_MSB:OP_LSB];
   assign rs = instr[RS_MSB:RS_LSB];
   assign rt = instr[RT_MSB:RT_LSB];
   assign rd = instr[RD_MSB:RD_LSB];

   reg_file_2r1w #(
      .DATA_W    (DATA_W),
      .NUM_REGS  (NUM_REGS),
      .REG_IDX_W (REG_IDX_W)
   ) u_reg_file (
      .clk     (clk),
      .reset_n (reset_n),
      .raddr1  (rs),
      .rdata1  (rf_rd1),
      .raddr2  (rt),
      .rdata2  (rf_rd2),
      .wen     (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data)
   );

   always_comb begin
      uses_rs    = (op != OP_JMP);
      uses_rt    = (op == OP_ADD) || (op == OP_SW);
      writes_reg = (op == OP_ADD) || (op == OP_LW);
      dest_d     = (op == OP_LW) ? rt : rd;
      sext_d     = {{(DATA_W-2){rd[1]}}, rd};
      // A source being written back this cycle is satisfied through the bypass.
      hz = (uses_rs && pend_q[rs] && !(wb_en && (wb_addr == rs))) ||
           (uses_rt && pend_q[rt] && !(wb_en && (wb_addr == rt)));
      instr_ready = reset_n && (!op_valid_q || op_ready) && !hz;
      load        = instr_valid && instr_ready;
   end

   // Set on issue beats clear on writeback for the same register.
   always_comb begin
      pend_d = pend_q;
      if (wb_en) begin
         pend_d[wb_addr] = 1'b0;
      end
      if (load && writes_reg) begin
         pend_d[dest_d] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q      <= '0;
         op_valid_q  <= 1'b0;
         op_code_q   <= '0;
         dest_q      <= '0;
         readdata1_q <= '0;
         readdata2_q <= '0;
         sext_q      <= '0;
         alusrc_q    <= 1'b0;
      end else begin
         pend_q <= pend_d;
         if (load) begin
            op_valid_q  <= 1'b1;
            op_code_q   <= op;
            dest_q      <= dest_d;
            readdata1_q <= rf_rd1;
            readdata2_q <= rf_rd2;
            sext_q      <= sext_d;
            alusrc_q    <= (op == OP_LW) || (op == OP_SW);
         end else if (op_ready) begin
            op_valid_q <= 1'b0;
         end
      end
   end

   assign op_valid      = op_valid_q;
   assign op_code       = op_code_q;
   assign dest          = dest_q;
   assign readdata1     = readdata1_q;
   assign readdata2     = readdata2_q;
   assign sign_extended = sext_q;
   assign alusrc        = alusrc_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, decode, bypass, RAW stall,
// backpressure and reset during a stall, with hand-computed expectations.
module tb_operand_fetch_stage;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr;
   logic       wb_en;
   logic [1:0] wb_addr;
   logic [7:0] wb_data;
   logic       op_valid;
   logic       op_ready;
   logic [1:0] op_code;
   logic [1:0] dest;
   logic [7:0] readdata1;
   logic [7:0] readdata2;
   logic [7:0] sign_extended;
   logic       alusrc;

   int vectors = 0;
   int miscompares = 0;

   operand_fetch_stage dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .wb_en         (wb_en),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .op_valid      (op_valid),
      .op_ready      (op_ready),
      .op_code       (op_code),
      .dest          (dest),
      .readdata1     (readdata1),
      .readdata2     (readdata2),
      .sign_extended (sign_extended),
      .alusrc        (alusrc)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; instr_valid = 1'b0; instr = 8'h00; wb_en = 1'b0;
      wb_addr = 2'd0; wb_data = 8'h00; op_ready = 1'b1;
      #12;
      vectors++; if (op_valid !== 1'b0) begin miscompares++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
      vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL reset_instr_ready: got %b want 0", instr_ready); end
      vectors++; if (readdata1 !== 8'h00) begin miscompares++; $display("FAIL reset_readdata1: got %h want 00", readdata1); end
      reset_n = 1'b1;
      step();
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b want 1", instr_ready); end
   endtask

   // add r1 = r2 + r3; afterwards pend[1] is set
   task automatic test_add();
      instr = 8'h2D; instr_valid = 1'b1;
      #1;
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL add_ready: got %b want 1", instr_ready); end
      step();
      instr_valid = 1'b0;
      vectors++; if (op_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b want 1", op_valid); end
      vectors++; if (op_code !== 2'b00) begin miscompares++; $display("FAIL add_opcode: got %b want 00", op_code); end
      vectors++; if (readdata1 !== 8'h00) begin miscompares++; $display("FAIL add_rd1: got %h want 00", readdata1); end
      vectors++; if (readdata2 !== 8'h00) begin miscompares++; $display("FAIL add_rd2: got %h want 00", readdata2); end
      vectors++; if (alusrc !== 1'b0) begin miscompares++; $display("FAIL add_alusrc: got %b want 0", alusrc); end
      vectors++; if (dest !== 2'd1) begin miscompares++; $display("FAIL add_dest: got %0d want 1", dest); end
      vectors++; if (sign_extended !== 8'h01) begin miscompares++; $display("FAIL add_sext: got %h want 01", sign_extended); end
      step();
      vectors++; if (op_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain: got %b want 0", op_valid); end
   endtask

   task automatic test_lw();
      wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'h11;
      step();
      wb_addr = 2'd3; wb_data = 8'h22;
      step();
      wb_en = 1'b0;
      instr = 8'h67; instr_valid = 1'b1;
      #1;
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL lw_ready: got %b want 1", instr_ready); end
      step();
      instr_valid = 1'b0;
      vectors++; if (op_valid !== 1'b1) begin miscompares++; $display("FAIL lw_valid: got %b want 1", op_valid); end
      vectors++; if (op_code !== 2'b01) begin miscompares++; $display("FAIL lw_opcode: got %b want 01", op_code); end
      vectors++; if (readdata1 !== 8'h11) begin miscompares++; $display("FAIL lw_rd1: got %h want 11", readdata1); end
      vectors++; if (readdata2 !== 8'h00) begin miscompares++; $display("FAIL lw_rd2: got %h want 00", readdata2); end
      vectors++; if (sign_extended !== 8'hFF) begin miscompares++; $display("FAIL lw_sext: got %h want ff", sign_extended); end
      vectors++; if (alusrc !== 1'b1) begin miscompares++; $display("FAIL lw_alusrc: got %b want 1", alusrc); end
      vectors++; if (dest !== 2'd1) begin miscompares++; $display("FAIL lw_dest: got %0d want 1", dest); end
      step();
   endtask

   // add r3 = r2 + r0 while r2 is written back in the same cycle
   task automatic test_bypass();
      wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'h5A;
      instr = 8'h23; instr_valid = 1'b1;
      #1;
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL byp_ready: got %b want 1", instr_ready); end
      step();
      wb_en = 1'b0;
      vectors++; if (readdata1 !== 8'h5A) begin miscompares++; $display("FAIL byp_rd1: got %h want 5a", readdata1); end
      vectors++; if (readdata2 !== 8'h00) begin miscompares++; $display("FAIL byp_rd2: got %h want 00", readdata2); end
      vectors++; if (dest !== 2'd3) begin miscompares++; $display("FAIL byp_dest: got %0d want 3", dest); end
      // sw reading r2 confirms the bypassed write landed
      instr = 8'hA0;
      step();
      instr_valid = 1'b0;
      vectors++; if (op_code !== 2'b10) begin miscompares++; $display("FAIL sw_opcode: got %b want 10", op_code); end
      vectors++; if (readdata1 !== 8'h5A) begin miscompares++; $display("FAIL sw_rd1: got %h want 5a", readdata1); end
      vectors++; if (alusrc !== 1'b1) begin miscompares++; $display("FAIL sw_alusrc: got %b want 1", alusrc); end
      step();
   endtask

   // pend = {r1, r3}; add r2 = r1 + r0 must wait for writeback of r1
   task automatic test_raw_stall();
      instr = 8'h12; instr_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall_ready[%0d]: got %b want 0", i, instr_ready); end
         step();
      end
      vectors++; if (op_valid !== 1'b0) begin miscompares++; $display("FAIL raw_stall_valid: got %b want 0", op_valid); end
      wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h77;
      #1;
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL raw_release_ready: got %b want 1", instr_ready); end
      step();
      wb_en = 1'b0; instr_valid = 1'b0;
      vectors++; if (op_valid !== 1'b1) begin miscompares++; $display("FAIL raw_valid: got %b want 1", op_valid); end
      vectors++; if (readdata1 !== 8'h77) begin miscompares++; $display("FAIL raw_rd1: got %h want 77", readdata1); end
      vectors++; if (dest !== 2'd2) begin miscompares++; $display("FAIL raw_dest: got %0d want 2", dest); end
   endtask

   // add bundle from the RAW test is held; jump then lw follow back-to-back
   task automatic test_back_to_back();
      op_ready = 1'b0;
      instr = 8'hC5; instr_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready[%0d]: got %b want 0", i, instr_ready); end
         vectors++; if (op_valid !== 1'b1 || readdata1 !== 8'h77 || dest !== 2'd2 || op_code !== 2'b00) begin
            miscompares++;
            $display("FAIL hold_bundle[%0d]: got v=%b rd1=%h dest=%0d op=%b want v=1 rd1=77 dest=2 op=00",
                     i, op_valid, readdata1, dest, op_code);
         end
         step();
      end
      op_ready = 1'b1;
      #1;
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b want 1", instr_ready); end
      step();
      vectors++; if (op_valid !== 1'b1 || op_code !== 2'b11) begin miscompares++; $display("FAIL jmp_bundle: got v=%b op=%b want v=1 op=11", op_valid, op_code); end
      vectors++; if (alusrc !== 1'b0) begin miscompares++; $display("FAIL jmp_alusrc: got %b want 0", alusrc); end
      vectors++; if (sign_extended !== 8'h01) begin miscompares++; $display("FAIL jmp_sext: got %h want 01", sign_extended); end
      instr = 8'h4E;
      #1;
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b want 1", instr_ready); end
      step();
      instr_valid = 1'b0;
      vectors++; if (op_valid !== 1'b1 || op_code !== 2'b01) begin miscompares++; $display("FAIL b2b_bundle: got v=%b op=%b want v=1 op=01", op_valid, op_code); end
      vectors++; if (sign_extended !== 8'hFE) begin miscompares++; $display("FAIL b2b_sext: got %h want fe", sign_extended); end
      vectors++; if (readdata1 !== 8'h00) begin miscompares++; $display("FAIL b2b_rd1: got %h want 00", readdata1); end
      vectors++; if (dest !== 2'd3) begin miscompares++; $display("FAIL b2b_dest: got %0d want 3", dest); end
      step();
   endtask

   task automatic test_reset_mid_stall();
      instr = 8'h44; instr_valid = 1'b1;
      step();
      instr = 8'h12;
      #1;
      vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL pre_reset_stall: got %b want 0", instr_ready); end
      vectors++; if (op_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid: got %b want 1", op_valid); end
      reset_n = 1'b0;
      #1;
      vectors++; if (op_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid: got %b want 0", op_valid); end
      vectors++; if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ready: got %b want 0", instr_ready); end
      #1;
      reset_n = 1'b1;
      #1;
      vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL pend_cleared: got %b want 1", instr_ready); end
      step();
      instr_valid = 1'b0;
      vectors++; if (op_valid !== 1'b1) begin miscompares++; $display("FAIL post_reset_issue: got %b want 1", op_valid); end
      vectors++; if (readdata1 !== 8'h00) begin miscompares++; $display("FAIL post_reset_r1: got %h want 00", readdata1); end
      step();
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_bypass();
      test_raw_stall();
      test_back_to_back();
      test_reset_mid_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
